// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller (load-use stall, branch flush, memory freeze)
module hazard_ctrl #(
  parameter int LOAD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic [4:0]  id_rd,
  input  logic        id_is_load,
  input  logic        id_w_enable,
  input  logic        beq_taken,
  input  logic        dm_busy,
  output logic        pc_w_enable,
  output logic        ifid_w_enable,
  output logic        buble_mux_ctrl,
  output logic        ifid_flush,
  output logic        mem_hold,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, STALL, FLUSH, WAIT} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [4:0]  ex_rd_q;
  logic        ex_load_q, ex_we_q;
  logic [15:0] stall_cnt_q;
  logic        ex_wr, load_use;

  // only an EX instruction that produces a register result can create a hazard
  assign ex_wr    = ex_we_q | ex_load_q;
  assign load_use = ex_load_q & ex_wr & (|ex_rd_q) &
                    ((id_uses_rs & (id_rs == ex_rd_q)) | (id_uses_rt & (id_rt == ex_rd_q)));
  assign stall_cnt = stall_cnt_q;

  // next state and control outputs; WAIT resumes with the normal RUN decode once memory is ready
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pc_w_enable    = 1'b1;
    ifid_w_enable  = 1'b1;
    buble_mux_ctrl = 1'b1;
    ifid_flush     = 1'b0;
    mem_hold       = 1'b0;
    if (rst) begin
      pc_w_enable    = 1'b0;
      ifid_w_enable  = 1'b0;
      buble_mux_ctrl = 1'b0;
      ifid_flush     = 1'b1;
      state_d        = RUN;
      cnt_d          = 2'd0;
    end else if (dm_busy) begin
      pc_w_enable   = 1'b0;
      ifid_w_enable = 1'b0;
      mem_hold      = 1'b1;
      state_d       = (state_q == RUN) ? WAIT : state_q;
    end else if (beq_taken) begin
      buble_mux_ctrl = 1'b0;
      ifid_flush     = 1'b1;
      state_d        = FLUSH;
      cnt_d          = 2'd0;
    end else if (state_q == FLUSH) begin
      buble_mux_ctrl = 1'b0;
      state_d        = RUN;
    end else if (state_q == STALL) begin
      pc_w_enable    = 1'b0;
      ifid_w_enable  = 1'b0;
      buble_mux_ctrl = 1'b0;
      cnt_d          = cnt_q - 2'd1;
      state_d        = (cnt_q == 2'd1) ? RUN : STALL;
    end else if (load_use) begin
      pc_w_enable    = 1'b0;
      ifid_w_enable  = 1'b0;
      buble_mux_ctrl = 1'b0;
      cnt_d          = 2'(LOAD_LAT - 1);
      state_d        = (LOAD_LAT == 1) ? RUN : STALL;
    end else begin
      state_d = RUN;
    end
  end

  // state, bubble counter, EX tracker and saturating stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= 2'd0;
      ex_rd_q     <= 5'd0;
      ex_load_q   <= 1'b0;
      ex_we_q     <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!mem_hold) begin
        ex_rd_q   <= buble_mux_ctrl ? id_rd : 5'd0;
        ex_load_q <= buble_mux_ctrl & id_is_load;
        ex_we_q   <= buble_mux_ctrl & id_w_enable;
      end
      if (!pc_w_enable && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

endmodule
